read_mem: RTL and testbench

- Read-side counterpart of write_mem: streams a programmed block of NSAMP_REG samples out of the same dual-port buffer memory, starting at ADDR_REG.
- Drives the memory read port (1-cycle read latency) and presents samples on an AXI4-Stream master with tlast on the final sample.
- Sits between the buffer memory and downstream DMA/stream logic in axis_qbuff.
- Started by a rising edge of START_REG; START_REG low aborts.

---
 rtl/read_mem.sv | 160 ++++++++++++++++
 tb/tb_read_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_mem.sv
// Streams a programmed block of samples out of a dual-port buffer memory onto an
// AXI4-Stream master, reading through a 1-cycle-latency memory read port.
module read_mem #(
    parameter int N = 8,
    parameter int B = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    output logic         mem_en,
    output logic [N-1:0] mem_addr,
    input  logic [B-1:0] mem_do,
    output logic [B-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         busy,
    output logic         done,
    input  logic         START_REG,
    input  logic [N-1:0] ADDR_REG,
    input  logic [N-1:0] NSAMP_REG
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic         start_r;
    logic         start_ev;
    logic [N-1:0] addr_base;
    logic [N-1:0] nsamp;
    logic [N-1:0] issued;
    logic [N-1:0] delivered;

    logic         rd_vld_p1;
    logic [B-1:0] fifo_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   fifo_cnt;

    logic         in_run;
    logic         issue;
    logic         push;
    logic         pop;
    logic         last_beat;

    // A new read may only go out if, after this cycle's pop, the buffered
    // entries plus the read whose data arrives next edge leave a free slot.
    function automatic logic has_room(input logic [1:0] cnt, input logic infl,
                                      input logic pp);
        logic [2:0] level;
        level = {1'b0, cnt} + {2'b00, infl} - {2'b00, pp};
        return level < 3'd2;
    endfunction

    assign start_ev  = START_REG && !start_r;
    assign in_run    = (state == S_RUN);
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign push      = rd_vld_p1 && in_run;
    assign issue     = in_run && (issued < nsamp) && has_room(fifo_cnt, rd_vld_p1, pop);
    assign last_beat = (delivered == nsamp - ONE);

    assign mem_en        = issue;
    assign mem_addr      = addr_base + issued;
    assign m_axis_tvalid = (fifo_cnt != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign busy          = in_run;
    assign done          = (state == S_DONE);

    // Control: start detection, block state, counters, read tracking.
    // start_r resets high so a START_REG already high at reset release is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            start_r   <= 1'b1;
            addr_base <= '0;
            nsamp     <= '0;
            issued    <= '0;
            delivered <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            start_r   <= START_REG;
            rd_vld_p1 <= issue && START_REG;
            case (state)
                S_IDLE: begin
                    if (start_ev) begin
                        addr_base <= ADDR_REG;
                        nsamp     <= NSAMP_REG;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (!START_REG) begin
                        state <= S_IDLE;
                    end else if (nsamp == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!START_REG) begin
                        state <= S_IDLE;
                    end else begin
                        if (issue) begin
                            issued <= issued + ONE;
                        end
                        if (pop) begin
                            delivered <= delivered + ONE;
                        end
                        if (pop && last_beat) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    if (!START_REG) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output FIFO bookkeeping; anything other than an active block flushes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (in_run && START_REG) begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end else begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end
    end

    // Memory data stage: the word requested last cycle lands in the FIFO.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_do;
        end
    end

endmodule

// File: tb/tb_read_mem.sv
// Bench for read_mem: a synchronous memory model feeds the DUT and every beat is
// compared against the sample sequence expected from the programmed block.
module tb_read_mem;

    localparam int N     = 8;
    localparam int B     = 4;
    localparam int DEPTH = 1 << N;

    logic         aclk;
    logic         aresetn;
    logic         mem_en;
    logic [N-1:0] mem_addr;
    logic [B-1:0] mem_do;
    logic [B-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         busy;
    logic         done;
    logic         START_REG;
    logic [N-1:0] ADDR_REG;
    logic [N-1:0] NSAMP_REG;

    logic [B-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    read_mem #(.N(N), .B(B)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_do        (mem_do),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .START_REG     (START_REG),
        .ADDR_REG      (ADDR_REG),
        .NSAMP_REG     (NSAMP_REG)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Buffer memory with one cycle of read latency.
    always @(posedge aclk) begin
        if (mem_en) mem_do <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) mem[i] = i[B-1:0];
    endtask

    task automatic fill_rand();
        for (int i = 0; i < DEPTH; i++) mem[i] = B'($urandom);
    endtask

    // Runs one block from a fresh start edge to DONE and back to IDLE.
    task automatic run_block(input int addr, input int ns, input bit rnd, input string tag);
        logic [B-1:0] expq[$];
        int           got;
        int           cyc;
        int           first_cyc;
        int           last_cyc;
        bit           hold;
        bit           rdy;
        logic [B-1:0] held_d;
        logic         held_l;
        for (int k = 0; k < ns; k++) expq.push_back(mem[(addr + k) % DEPTH]);
        ADDR_REG      = N'(addr);
        NSAMP_REG     = N'(ns);
        START_REG     = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        // Register changes after the start edge must not affect the block.
        ADDR_REG  = N'($urandom);
        NSAMP_REG = N'($urandom);
        check({tag, "/e0_busy"}, busy, 0);
        check({tag, "/e0_tvalid"}, m_axis_tvalid, 0);
        tick();
        if (ns == 0) begin
            check({tag, "/done"}, done, 1);
            check({tag, "/busy"}, busy, 0);
            check({tag, "/tvalid"}, m_axis_tvalid, 0);
            check({tag, "/mem_en"}, mem_en, 0);
            tick();
            check({tag, "/done_hold"}, done, 1);
            check({tag, "/tvalid_hold"}, m_axis_tvalid, 0);
        end else begin
            check({tag, "/e1_busy"}, busy, 1);
            check({tag, "/e1_mem_en"}, mem_en, 1);
            check({tag, "/e1_mem_addr"}, mem_addr, addr % DEPTH);
            cyc       = 1;
            got       = 0;
            first_cyc = -1;
            last_cyc  = -1;
            hold      = 1'b0;
            held_d    = '0;
            held_l    = 1'b0;
            while (got < ns && cyc < 20 * ns + 20) begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axis_tready = rdy;
                if (hold) begin
                    check({tag, "/stall_tvalid"}, m_axis_tvalid, 1);
                    check({tag, "/stall_tdata"}, m_axis_tdata, held_d);
                    check({tag, "/stall_tlast"}, m_axis_tlast, held_l);
                end
                if (m_axis_tvalid) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (rdy) begin
                        check({tag, "/tdata"}, m_axis_tdata, expq[got]);
                        check({tag, "/tlast"}, m_axis_tlast, (got == ns - 1));
                        last_cyc = cyc;
                        got++;
                        hold = 1'b0;
                    end else begin
                        hold   = 1'b1;
                        held_d = expq[got];
                        held_l = (got == ns - 1);
                    end
                end
                tick();
                cyc++;
            end
            check({tag, "/beats"}, got, ns);
            check({tag, "/done"}, done, 1);
            check({tag, "/busy_end"}, busy, 0);
            check({tag, "/tvalid_end"}, m_axis_tvalid, 0);
            if (!rnd) begin
                check({tag, "/first_lat"}, first_cyc, 3);
                check({tag, "/back2back"}, last_cyc - first_cyc, ns - 1);
            end
        end
        START_REG     = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check({tag, "/idle_done"}, done, 0);
        check({tag, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        int got;
        int cyc;
        aresetn       = 1'b0;
        START_REG     = 1'b0;
        ADDR_REG      = '0;
        NSAMP_REG     = '0;
        m_axis_tready = 1'b0;
        fill_ramp();
        tick();
        tick();
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/tvalid", m_axis_tvalid, 0);
        check("rst/tlast", m_axis_tlast, 0);
        check("rst/tdata", m_axis_tdata, 0);
        check("rst/mem_en", mem_en, 0);
        check("rst/mem_addr", mem_addr, 0);
        aresetn = 1'b1;
        tick();

        run_block(0, 10, 1'b0, "ramp");
        run_block(0, 10, 1'b1, "ramp_bp");
        run_block(250, 8, 1'b0, "wrap");
        run_block(0, 0, 1'b0, "empty");

        // Abort after four beats, then restart with a new block.
        ADDR_REG      = '0;
        NSAMP_REG     = N'(10);
        START_REG     = 1'b1;
        m_axis_tready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 30) begin
            if (m_axis_tvalid) begin
                check("abort/tdata", m_axis_tdata, got);
                check("abort/tlast", m_axis_tlast, 0);
                got++;
            end
            tick();
            cyc++;
        end
        check("abort/beats", got, 4);
        m_axis_tready = 1'b0;
        START_REG     = 1'b0;
        check("abort/tlast_pre", m_axis_tlast, 0);
        tick();
        check("abort/tvalid", m_axis_tvalid, 0);
        check("abort/tlast_post", m_axis_tlast, 0);
        check("abort/busy", busy, 0);
        check("abort/done", done, 0);
        ADDR_REG  = N'(7);
        NSAMP_REG = N'(5);
        repeat (20) tick();
        check("abort/idle_tvalid", m_axis_tvalid, 0);
        check("abort/idle_mem_en", mem_en, 0);
        run_block(7, 5, 1'b0, "resume");

        // Asynchronous reset while a beat is waiting.
        ADDR_REG      = '0;
        NSAMP_REG     = N'(10);
        START_REG     = 1'b1;
        m_axis_tready = 1'b0;
        cyc = 0;
        tick();
        while (!m_axis_tvalid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("arst/pre_tvalid", m_axis_tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("arst/tvalid", m_axis_tvalid, 0);
        check("arst/busy", busy, 0);
        check("arst/done", done, 0);
        check("arst/mem_en", mem_en, 0);
        check("arst/tlast", m_axis_tlast, 0);
        tick();
        tick();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("arst/quiet_tvalid", m_axis_tvalid, 0);
            check("arst/quiet_busy", busy, 0);
        end
        START_REG = 1'b0;
        tick();
        run_block(3, 6, 1'b1, "post_rst");

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run_block(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1'b1, "rand");
        end
        fill_rand();
        run_block(100, DEPTH - 1, 1'b0, "full");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
